// File: rtl/pkt_send_gen.sv
// Per-port packet source for the shared-cache switch.
// A start pulse in IDLE emits one packet on the write interface: a header beat,
// then `length` payload beats, followed by a one-cycle done pulse.
// The priority input is named `pri` because `priority` is a reserved word in SystemVerilog.
// rst_n is synchronous and active-high: asserted = 1, despite the suffix.
module pkt_send_gen #(
    parameter  int DATA_WIDTH      = 32,
    parameter  int PORT_NUB_TOTAL  = 4,
    parameter  int PRIORITY        = 8,
    parameter  int DATA_LENGTH_MAX = 512,
    localparam int W_SEL           = $clog2(PORT_NUB_TOTAL),
    localparam int W_PRI           = $clog2(PRIORITY),
    localparam int W_LEN           = $clog2(DATA_LENGTH_MAX)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W_SEL-1:0]      dest,
    input  logic [W_PRI-1:0]      pri,
    input  logic [W_LEN-1:0]      length,
    output logic                  done,
    output logic                  wr_sop,
    output logic                  wr_eop,
    output logic                  wr_vld,
    output logic [DATA_WIDTH-1:0] wr_data
);

    // The state names the beat currently on the outputs: IDLE also covers the done cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t           state;
    logic [W_SEL-1:0] cap_dest;
    logic [W_PRI-1:0] cap_pri;
    logic [W_LEN-1:0] cap_len;
    logic [W_LEN-1:0] beat_cnt;
    logic [15:0]      seq;

    // Header: dest in the low bits, then priority, length and the sequence number. Upper bits are 0.
    function automatic logic [DATA_WIDTH-1:0] make_hdr(
        input logic [W_SEL-1:0] d,
        input logic [W_PRI-1:0] p,
        input logic [W_LEN-1:0] l,
        input logic [15:0]      s
    );
        logic [DATA_WIDTH-1:0] h;
        h                              = '0;
        h[W_SEL-1:0]                   = d;
        h[W_SEL +: W_PRI]              = p;
        h[W_SEL+W_PRI +: W_LEN]        = l;
        h[W_SEL+W_PRI+W_LEN +: 16]     = s;
        return h;
    endfunction

    // Payload beat k: the beat index in [15:0] and the sequence number in [31:16].
    function automatic logic [DATA_WIDTH-1:0] make_payload(
        input logic [W_LEN-1:0] k,
        input logic [15:0]      s
    );
        logic [DATA_WIDTH-1:0] p;
        p        = '0;
        p[15:0]  = 16'(k);
        p[31:16] = s;
        return p;
    endfunction

    // Packet FSM. Every output is driven from this one registered block.
    // NOTE: sequential state uses non-blocking (<=) so that every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            cap_dest <= '0;
            cap_pri  <= '0;
            cap_len  <= '0;
            beat_cnt <= '0;
            seq      <= '0;
            done     <= 1'b0;
            wr_sop   <= 1'b0;
            wr_eop   <= 1'b0;
            wr_vld   <= 1'b0;
            wr_data  <= '0;
        end else begin
            // Idle defaults. Each state overrides these only when it drives a beat.
            done    <= 1'b0;
            wr_sop  <= 1'b0;
            wr_eop  <= 1'b0;
            wr_vld  <= 1'b0;
            wr_data <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        cap_dest <= dest;
                        cap_pri  <= pri;
                        cap_len  <= length;
                        wr_vld   <= 1'b1;
                        wr_sop   <= 1'b1;
                        wr_eop   <= (length == '0);
                        wr_data  <= make_hdr(dest, pri, length, seq);
                        state    <= HDR;
                    end
                end

                HDR: begin
                    if (cap_len == '0) begin
                        // The header was also the last beat.
                        done  <= 1'b1;
                        seq   <= seq + 16'd1;
                        state <= IDLE;
                    end else begin
                        beat_cnt <= W_LEN'(1);
                        wr_vld   <= 1'b1;
                        wr_eop   <= (cap_len == W_LEN'(1));
                        wr_data  <= make_payload(W_LEN'(1), seq);
                        state    <= BODY;
                    end
                end

                BODY: begin
                    if (beat_cnt == cap_len) begin
                        done  <= 1'b1;
                        seq   <= seq + 16'd1;
                        state <= IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + W_LEN'(1);
                        wr_vld   <= 1'b1;
                        wr_eop   <= ((beat_cnt + W_LEN'(1)) == cap_len);
                        wr_data  <= make_payload(beat_cnt + W_LEN'(1), seq);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_send_gen.sv
// Directed bench for pkt_send_gen. Inputs are driven on the falling edge and
// outputs are sampled there as well, half a cycle away from the active edge.
module tb_pkt_send_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  dest;
    logic [2:0]  pri;
    logic [8:0]  length;
    logic        done;
    logic        wr_sop;
    logic        wr_eop;
    logic        wr_vld;
    logic [31:0] wr_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pkt_send_gen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dest    (dest),
        .pri     (pri),
        .length  (length),
        .done    (done),
        .wr_sop  (wr_sop),
        .wr_eop  (wr_eop),
        .wr_vld  (wr_vld),
        .wr_data (wr_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // All outputs at rest: no beat, no done, data 0.
    task automatic check_quiet(input string tag);
        check({tag, " ctl"}, {28'd0, done, wr_sop, wr_eop, wr_vld}, 32'd0);
        check({tag, " data"}, wr_data, 32'd0);
    endtask

    // Starts at a falling edge: pulses start with the given fields and then checks the
    // header, every payload beat and the done cycle. It returns at the done-cycle
    // falling edge so that the caller can chain a start there.
    // inject_k > 0: pulses a foreign start after payload beat inject_k.
    // abort_k  > 0: asserts reset after payload beat abort_k and checks the abort.
    task automatic run_pkt(input logic [1:0] d, input logic [2:0] p, input logic [8:0] l,
                           input logic [31:0] exp_hdr, input logic [15:0] s,
                           input int inject_k, input int abort_k);
        start  = 1'b1;
        dest   = d;
        pri    = p;
        length = l;
        @(negedge clk);
        start  = 1'b0;
        dest   = '0;
        pri    = '0;
        length = '0;
        check("hdr vld",  {31'd0, wr_vld}, 32'd1);
        check("hdr sop",  {31'd0, wr_sop}, 32'd1);
        check("hdr eop",  {31'd0, wr_eop}, {31'd0, (l == 9'd0)});
        check("hdr done", {31'd0, done},   32'd0);
        check("hdr data", wr_data, exp_hdr);
        for (int k = 1; k <= int'(l); k++) begin
            @(negedge clk);
            start = 1'b0;
            check("pay vld",  {31'd0, wr_vld}, 32'd1);
            check("pay sop",  {31'd0, wr_sop}, 32'd0);
            check("pay eop",  {31'd0, wr_eop}, {31'd0, (k == int'(l))});
            check("pay data", wr_data, {s, 16'(k)});
            if (k == inject_k) begin
                start  = 1'b1;
                dest   = 2'd1;
                pri    = 3'd0;
                length = 9'd3;
            end
            if (k == abort_k) begin
                rst_n = 1'b1;
                @(negedge clk);
                rst_n = 1'b0;
                check_quiet("abort");
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("done pulse", {31'd0, done}, 32'd1);
        check("done vld",   {29'd0, wr_sop, wr_eop, wr_vld}, 32'd0);
        check("done data",  wr_data, 32'd0);
    endtask

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        dest   = '0;
        pri    = '0;
        length = '0;

        // 1. Hold reset for 10 cycles with start toggling. Outputs must stay 0.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) check_quiet("reset");
            start  = i[0];
            dest   = 2'd3;
            length = 9'd4;
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("post reset idle");
        end

        // 2. dest=2 pri=1 len=10 with seq 0: header 0x146.
        run_pkt(2'd2, 3'd1, 9'd10, 32'h0000_0146, 16'd0, 0, 0);
        @(negedge clk);
        check_quiet("done drop");

        // 3. Same request again with seq 1: header 0x4146.
        run_pkt(2'd2, 3'd1, 9'd10, 32'h0000_4146, 16'd1, 0, 0);
        @(negedge clk);

        // 4. len=0 dest=3 pri=7 with seq 2: a single sop+eop beat, 0x1F | 2<<14.
        run_pkt(2'd3, 3'd7, 9'd0, 32'h0000_801F, 16'd2, 0, 0);
        @(negedge clk);
        check_quiet("len0 after done");

        // 5. A start mid-BODY is ignored. A start in the done cycle chains straight in.
        //    Packet seq 3: header 0x146 | 3<<14 = 0xC146.
        run_pkt(2'd2, 3'd1, 9'd10, 32'h0000_C146, 16'd3, 4, 0);
        //    dest=1 pri=2 len=2 with seq 4: 0x01 | 0x08 | 0x40 | 4<<14 = 0x10049.
        run_pkt(2'd1, 3'd2, 9'd2, 32'h0001_0049, 16'd4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_quiet("no extra pkt");
        end

        // 6. Reset during beat 5. dest=0 pri=0 len=10 with seq 5: 0x140 | 5<<14 = 0x14140.
        run_pkt(2'd0, 3'd0, 9'd10, 32'h0001_4140, 16'd5, 0, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_quiet("after abort");
        end
        //    seq restarts at 0 after the reset.
        run_pkt(2'd2, 3'd1, 9'd10, 32'h0000_0146, 16'd0, 0, 0);
        @(negedge clk);
        check_quiet("final idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
